// File: rtl/load_unit_pkg.sv
// load_unit_pkg
// Shared definitions for the load unit: FSM state encoding, RISC-V load
// funct3 encodings, the default memory-mapped hardware counter address and
// small decode helpers used by the top level and the alignment block.

`ifndef HARDWARE_COUNTER_ADDR
`define HARDWARE_COUNTER_ADDR 64'h0000_0000_0000_F000
`endif

package load_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Held at 64 bits so either XLEN can take its low slice as a default.
    localparam logic [63:0] HW_COUNTER_ADDR = `HARDWARE_COUNTER_ADDR;

    // Access size in bytes; funct3[1:0] encodes log2(size) for every load.
    function automatic int f3_size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 8;
        endcase
    endfunction

    // LD and LWU only exist on a 64-bit datapath.
    function automatic logic f3_is_legal(input logic [2:0] f3, input int xlen);
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            F3_LD, F3_LWU:                       return (xlen == 64);
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align
// Combinational extraction of a load result from a two-word window.
// Ports:
//   lo, hi   - low and high memory words (hi is zero for single-beat loads)
//   offset   - byte offset of the load inside the low word
//   funct3   - load type (size in [1:0], unsigned flag in [2])
//   data     - right-aligned, sign/zero-extended result

module load_align
    import load_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]            lo,
    input  logic [XLEN-1:0]            hi,
    input  logic [$clog2(XLEN/8)-1:0]  offset,
    input  logic [2:0]                 funct3,
    output logic [XLEN-1:0]            data
);

    logic [XLEN-1:0] word;
    logic [XLEN-1:0] mask;
    logic            sign_bit;

    // Shift the {hi,lo} pair so the addressed byte lands at bit 0; only the
    // low XLEN bits can ever be part of the result.
    assign word = XLEN'({hi, lo} >> {offset, 3'b000});

    always_comb begin
        mask     = '1;
        sign_bit = 1'b0;
        case (f3_size_bytes(funct3))
            1: begin
                mask     = XLEN'(8'hFF);
                sign_bit = word[7];
            end
            2: begin
                mask     = XLEN'(16'hFFFF);
                sign_bit = word[15];
            end
            4: begin
                mask     = XLEN'(32'hFFFF_FFFF);
                sign_bit = word[31];
            end
            default: ;
        endcase
        data = word & mask;
        // funct3[2] marks the unsigned variants; a full-width load has an
        // all-ones mask so the extension term vanishes.
        if (!funct3[2] && sign_bit) begin
            data = data | ~mask;
        end
    end

endmodule

// File: rtl/load_unit.sv
// load_unit
// Single-outstanding load unit. Accepts one load at a time, reads one or two
// aligned memory words, aligns/extends the result and returns it with a
// one-cycle response strobe. Full-width loads of COUNTER_ADDR return the live
// hardware counter without touching memory.
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   req_valid/req_ready       - request handshake (ready only in IDLE)
//   req_addr, req_funct3      - byte address and load type
//   counter                   - live hardware counter value
//   mem_req, mem_addr         - memory read strobe and word-aligned address
//   mem_rvalid, mem_rdata     - memory read return
//   rsp_valid, rsp_data, rsp_err - response strobe, result, error flag

module load_unit
    import load_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] COUNTER_ADDR = HW_COUNTER_ADDR[XLEN-1:0],
    parameter bit              MISALIGN_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] counter,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err
);

    localparam int         NBYTES  = XLEN / 8;
    localparam int         OFFW    = $clog2(NBYTES);
    localparam logic [2:0] FULL_F3 = (XLEN == 64) ? F3_LD : F3_LW;

    state_e          state_q,    state_d;
    logic [XLEN-1:0] addr_q,     addr_d;
    logic [2:0]      funct3_q,   funct3_d;
    logic            misal_q,    misal_d;
    logic [XLEN-1:0] lo_q,       lo_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_err_q,  rsp_err_d;

    logic            req_legal;
    logic            req_misaligned;
    logic            req_counter_hit;
    logic [XLEN-1:0] addr_aligned;
    logic [XLEN-1:0] align_lo;
    logic [XLEN-1:0] align_hi;
    logic [XLEN-1:0] align_data;

    // Request decode, evaluated on the live request inputs in IDLE.
    assign req_legal       = f3_is_legal(req_funct3, XLEN);
    assign req_misaligned  = (int'(req_addr[OFFW-1:0]) + f3_size_bytes(req_funct3)) > NBYTES;
    assign req_counter_hit = (req_funct3 == FULL_F3) && (req_addr == COUNTER_ADDR);

    assign addr_aligned = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};

    // In BEAT1 the first word is already captured and the live return data is
    // the high word; otherwise the live return is the only (low) word.
    assign align_lo = (state_q == BEAT1) ? lo_q      : mem_rdata;
    assign align_hi = (state_q == BEAT1) ? mem_rdata : '0;

    load_align #(
        .XLEN (XLEN)
    ) u_align (
        .lo     (align_lo),
        .hi     (align_hi),
        .offset (addr_q[OFFW-1:0]),
        .funct3 (funct3_q),
        .data   (align_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        misal_d    = misal_q;
        lo_d       = lo_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        rsp_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    misal_d  = req_misaligned;
                    if (!req_legal || (req_misaligned && !MISALIGN_EN)) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end else if (req_counter_hit) begin
                        // Counter value is sampled at the acceptance edge.
                        rsp_data_d = counter;
                        rsp_err_d  = 1'b0;
                        state_d    = RESP;
                    end else begin
                        state_d = BEAT0;
                    end
                end
            end
            BEAT0: begin
                mem_req  = 1'b1;
                mem_addr = addr_aligned;
                if (mem_rvalid) begin
                    if (misal_q) begin
                        lo_d    = mem_rdata;
                        state_d = BEAT1;
                    end else begin
                        rsp_data_d = align_data;
                        rsp_err_d  = 1'b0;
                        state_d    = RESP;
                    end
                end
            end
            BEAT1: begin
                mem_req  = 1'b1;
                mem_addr = addr_aligned + XLEN'(NBYTES);
                if (mem_rvalid) begin
                    rsp_data_d = align_data;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            funct3_q   <= '0;
            misal_q    <= 1'b0;
            lo_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            misal_q    <= misal_d;
            lo_q       <= lo_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit
// Directed bench for load_unit at XLEN=32: one instance with split misaligned
// loads enabled and one that flags misaligned loads as errors.

module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid_m = 1'b0;
    logic        req_valid_s = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] counter = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        m_req_ready, m_mem_req, m_rsp_valid, m_rsp_err;
    logic [31:0] m_mem_addr, m_rsp_data;
    logic        s_req_ready, s_mem_req, s_rsp_valid, s_rsp_err;
    logic [31:0] s_mem_addr, s_rsp_data;

    int total = 0;
    int bad = 0;
    bit sel_strict = 1'b0;

    logic        o_req_ready, o_mem_req, o_rsp_valid, o_rsp_err;
    logic [31:0] o_mem_addr, o_rsp_data;

    assign o_req_ready = sel_strict ? s_req_ready : m_req_ready;
    assign o_mem_req   = sel_strict ? s_mem_req   : m_mem_req;
    assign o_rsp_valid = sel_strict ? s_rsp_valid : m_rsp_valid;
    assign o_rsp_err   = sel_strict ? s_rsp_err   : m_rsp_err;
    assign o_mem_addr  = sel_strict ? s_mem_addr  : m_mem_addr;
    assign o_rsp_data  = sel_strict ? s_rsp_data  : m_rsp_data;

    always #5 clk = ~clk;

    load_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid_m),
        .req_ready  (m_req_ready),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .counter    (counter),
        .mem_req    (m_mem_req),
        .mem_addr   (m_mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (m_rsp_valid),
        .rsp_data   (m_rsp_data),
        .rsp_err    (m_rsp_err)
    );

    load_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) u_dut_strict (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid_s),
        .req_ready  (s_req_ready),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .counter    (counter),
        .mem_req    (s_mem_req),
        .mem_addr   (s_mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (s_rsp_valid),
        .rsp_data   (s_rsp_data),
        .rsp_err    (s_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one load, serves each memory beat after a one-cycle stall, and
    // checks addresses, latency, result, one-cycle strobe and hold.
    task automatic run_load(input string tag, input bit strict,
                            input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input int exp_beats, input logic [31:0] exp_a0,
                            input logic [31:0] exp_data, input logic exp_err);
        int          beats = 0;
        int          cyc = 0;
        bit          delivering = 1'b0;
        bit          done = 1'b0;
        logic [31:0] ea;
        sel_strict = strict;
        @(negedge clk);
        check({tag, ".ready"}, {31'b0, o_req_ready}, 32'd1);
        req_addr   = addr;
        req_funct3 = f3;
        if (strict) req_valid_s = 1'b1;
        else        req_valid_m = 1'b1;
        @(negedge clk);
        req_valid_m = 1'b0;
        req_valid_s = 1'b0;
        counter     = counter + 32'd57;
        while (!done && cyc < 20) begin
            if (o_rsp_valid) begin
                check({tag, ".lat"},   cyc,   32'(2 * exp_beats));
                check({tag, ".beats"}, beats, 32'(exp_beats));
                check({tag, ".data"},  o_rsp_data, exp_data);
                check({tag, ".err"},   {31'b0, o_rsp_err}, {31'b0, exp_err});
                done = 1'b1;
            end else if (o_mem_req) begin
                ea = exp_a0 + 32'(4 * beats);
                check({tag, ".maddr"}, o_mem_addr, ea);
                if (!delivering) begin
                    delivering = 1'b1;
                end else begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = (beats == 0) ? w0 : w1;
                    beats++;
                    delivering = 1'b0;
                end
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
            cyc++;
        end
        if (!done) begin
            check({tag, ".timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, ".pulse"}, {31'b0, o_rsp_valid}, 32'd0);
            check({tag, ".hold"},  o_rsp_data, exp_data);
            check({tag, ".idle"},  {31'b0, o_req_ready}, 32'd1);
        end
        $display("load %s addr=0x%08h f3=%0d data=0x%08h err=%0b beats=%0d", tag, addr, f3, o_rsp_data, o_rsp_err, beats);
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst.mem_req",   {31'b0, m_mem_req},   32'd0);
        check("rst.mem_addr",  m_mem_addr,           32'd0);
        check("rst.rsp_valid", {31'b0, m_rsp_valid}, 32'd0);
        check("rst.rsp_data",  m_rsp_data,           32'd0);
        check("rst.rsp_err",   {31'b0, m_rsp_err},   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.ready", {31'b0, m_req_ready}, 32'd1);

        run_load("lw_aligned", 0, 32'h100, 3'b010, 32'hDEADBEEF, 32'h0, 1, 32'h100, 32'hDEADBEEF, 1'b0);
        run_load("lb_neg",     0, 32'h103, 3'b000, 32'h80112233, 32'h0, 1, 32'h100, 32'hFFFFFF80, 1'b0);
        run_load("lbu",        0, 32'h103, 3'b100, 32'h80112233, 32'h0, 1, 32'h100, 32'h00000080, 1'b0);
        run_load("lw_split",   0, 32'h102, 3'b010, 32'h11223344, 32'h55667788, 2, 32'h100, 32'h77881122, 1'b0);
        run_load("lh_hi",      0, 32'h102, 3'b001, 32'h80011234, 32'h0, 1, 32'h100, 32'hFFFF8001, 1'b0);
        run_load("lhu_hi",     0, 32'h102, 3'b101, 32'h80011234, 32'h0, 1, 32'h100, 32'h00008001, 1'b0);
        run_load("lh_split",   0, 32'h003, 3'b001, 32'hAB000000, 32'h000000CD, 2, 32'h000, 32'hFFFFCDAB, 1'b0);
        counter = 32'd42;
        run_load("ctr_hit",    0, 32'hF000, 3'b010, 32'h0, 32'h0, 0, 32'h0, 32'd42, 1'b0);
        run_load("lh_at_ctr",  0, 32'hF000, 3'b001, 32'h0000BEEF, 32'h0, 1, 32'hF000, 32'hFFFFBEEF, 1'b0);
        run_load("f3_011",     0, 32'h100, 3'b011, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1'b1);
        run_load("f3_110",     0, 32'h100, 3'b110, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1'b1);
        run_load("f3_111",     0, 32'h100, 3'b111, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1'b1);
        run_load("lw_wrap",    0, 32'hFFFFFFFE, 3'b010, 32'h44332211, 32'h88776655, 2, 32'hFFFFFFFC, 32'h66554433, 1'b0);
        run_load("strict_lh_mis",  1, 32'h003, 3'b001, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1'b1);
        run_load("strict_lw",      1, 32'h100, 3'b010, 32'hCAFEF00D, 32'h0, 1, 32'h100, 32'hCAFEF00D, 1'b0);
        run_load("strict_lb_edge", 1, 32'h103, 3'b000, 32'h7F000000, 32'h0, 1, 32'h100, 32'h0000007F, 1'b0);

        // Reset asserted while the split load waits in BEAT1.
        sel_strict = 1'b0;
        @(negedge clk);
        req_addr    = 32'h102;
        req_funct3  = 3'b010;
        req_valid_m = 1'b1;
        @(negedge clk);
        req_valid_m = 1'b0;
        check("rstmid.beat0", {31'b0, m_mem_req}, 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11223344;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rstmid.beat1_req",  {31'b0, m_mem_req}, 32'd1);
        check("rstmid.beat1_addr", m_mem_addr, 32'h104);
        rst_n = 1'b0;
        #1;
        check("rstmid.mem_req",   {31'b0, m_mem_req},   32'd0);
        check("rstmid.mem_addr",  m_mem_addr,           32'd0);
        check("rstmid.rsp_valid", {31'b0, m_rsp_valid}, 32'd0);
        check("rstmid.rsp_data",  m_rsp_data,           32'd0);
        @(negedge clk);
        check("rstmid.no_rsp", {31'b0, m_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid.ready",   {31'b0, m_req_ready}, 32'd1);
        check("rstmid.no_rsp2", {31'b0, m_rsp_valid}, 32'd0);
        check("rstmid.no_mem",  {31'b0, m_mem_req},   32'd0);
        $display("reset mid-load ready=%0b rsp_valid=%0b", m_req_ready, m_rsp_valid);

        run_load("post_rst_lw", 0, 32'h200, 3'b010, 32'h0BADF00D, 32'h0, 1, 32'h200, 32'h0BADF00D, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
